deit_tile_scheduler: RTL and testbench

Sequences `deit_core` over a GEMM job of N output tiles × K accumulation passes. It tracks when the weight and input buffers are loaded, launches one core pass at a time, and drives the accumulate-mode and output-enable controls on each pass. After the final pass it drains the output buffer and reports completion. It sits between the AXI-Lite control register block and the core, replacing direct host toggling of start, acc_mode and output_en.

---
 rtl/deit_tile_scheduler_pkg.sv | 27 ++
 rtl/deit_tile_scheduler_watchdog.sv | 38 +++
 rtl/deit_tile_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_deit_tile_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/deit_tile_scheduler_pkg.sv
// Shared definitions for the DeiT tile scheduler: FSM state encoding and
// default widths.
package deit_tile_scheduler_pkg;

  localparam int unsigned SCH_CNT_W = 16;

  typedef enum logic [2:0] {
    SCH_IDLE      = 3'd0,
    SCH_WAIT_DATA = 3'd1,
    SCH_LAUNCH    = 3'd2,
    SCH_RUN       = 3'd3,
    SCH_DRAIN     = 3'd4,
    SCH_DONE      = 3'd5,
    SCH_ERROR     = 3'd6
  } sch_state_e;

  function automatic logic sch_is_busy(input sch_state_e s);
    return (s == SCH_WAIT_DATA) || (s == SCH_LAUNCH) || (s == SCH_RUN) ||
           (s == SCH_DRAIN) || (s == SCH_DONE);
  endfunction

  // States in which the watchdog accumulates time.
  function automatic logic sch_is_timed(input sch_state_e s);
    return (s == SCH_WAIT_DATA) || (s == SCH_RUN) || (s == SCH_DRAIN);
  endfunction

endpackage

// File: rtl/deit_tile_scheduler_watchdog.sv
// Loadable saturating cycle counter with clear, enable and terminal compare.
// A zero limit disables the terminal output.
module sched_watchdog #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_cnt,
  output logic         o_hit
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)
      cnt_d = '0;
    else if (i_load)
      cnt_d = i_load_val;
    else if (i_en && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;
  // Fires on the last counted cycle so the exit lands exactly i_limit cycles in.
  assign o_hit = i_en && (i_limit != '0) && (cnt_q == i_limit - W'(1));

endmodule

// File: rtl/deit_tile_scheduler.sv
// Sequences deit_core over N output tiles x K accumulation passes: waits for
// weight/input buffers, launches passes, drives acc/output controls, drains.
module deit_tile_scheduler
  import deit_tile_scheduler_pkg::*;
#(
  parameter int unsigned CNT_W       = SCH_CNT_W,
  parameter int unsigned TMO_W       = 24,
  parameter int unsigned DRAIN_GUARD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_start,
  input  logic             i_cmd_abort,
  input  logic [CNT_W-1:0] i_cfg_k_tiles,
  input  logic [CNT_W-1:0] i_cfg_n_tiles,
  input  logic [31:0]      i_cfg_compute_cycles,
  input  logic [TMO_W-1:0] i_cfg_timeout,
  input  logic             i_wbuf_ready,
  input  logic             i_ibuf_ready,
  input  logic             i_core_done,
  input  logic             i_core_idle,
  input  logic             i_obuf_empty,
  output logic             o_core_start,
  output logic [31:0]      o_cfg_compute_cycles,
  output logic             o_cfg_acc_mode,
  output logic             o_cfg_output_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err_timeout,
  output logic             o_err_overrun,
  output logic [CNT_W-1:0] o_k_idx,
  output logic [CNT_W-1:0] o_n_idx
);

  sch_state_e       state_q, state_d;
  logic [CNT_W-1:0] k_last_q, k_last_d, n_last_q, n_last_d;
  logic [CNT_W-1:0] k_idx_q, k_idx_d, n_idx_q, n_idx_d;
  logic [31:0]      cc_q, cc_d;
  logic             w_rdy_q, w_rdy_d, i_rdy_q, i_rdy_d;
  logic             acc_q, acc_d, oen_q, oen_d;
  logic             err_tmo_q, err_tmo_d, err_ovr_q, err_ovr_d;

  logic             active, start_ok, consume, w_set, i_set, data_ok;
  logic             last_k, last_n, pass_done, guard_ok;
  logic             wd_en, wd_clr, wd_hit;
  logic [TMO_W-1:0] wd_cnt;

  assign active    = (state_q != SCH_IDLE) && (state_q != SCH_ERROR);
  assign start_ok  = i_cmd_start && !active;
  assign consume   = (state_q == SCH_LAUNCH);
  assign w_set     = i_wbuf_ready && active;
  assign i_set     = i_ibuf_ready && active;
  // A pulse in the deciding cycle counts, so launch follows the condition by one cycle.
  assign data_ok   = (w_rdy_q || w_set) && (i_rdy_q || i_set) && i_core_idle;
  assign last_k    = (k_idx_q == k_last_q);
  assign last_n    = (n_idx_q == n_last_q);
  assign pass_done = (state_q == SCH_RUN) && i_core_done;
  assign guard_ok  = (wd_cnt >= TMO_W'(DRAIN_GUARD));

  assign wd_en  = sch_is_timed(state_q);
  assign wd_clr = (state_d != state_q);

  sched_watchdog #(.W(TMO_W)) u_wdog (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (wd_clr),
    .i_en       (wd_en),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_limit    (i_cfg_timeout),
    .o_cnt      (wd_cnt),
    .o_hit      (wd_hit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCH_IDLE, SCH_ERROR: if (i_cmd_start) state_d = SCH_WAIT_DATA;
      SCH_WAIT_DATA: begin
        if (data_ok)     state_d = SCH_LAUNCH;
        else if (wd_hit) state_d = SCH_ERROR;
      end
      SCH_LAUNCH: state_d = SCH_RUN;
      SCH_RUN: begin
        if (i_core_done) state_d = (last_k && last_n) ? SCH_DRAIN : SCH_WAIT_DATA;
        else if (wd_hit) state_d = SCH_ERROR;
      end
      SCH_DRAIN: begin
        if (guard_ok && i_obuf_empty) state_d = SCH_DONE;
        else if (wd_hit)              state_d = SCH_ERROR;
      end
      SCH_DONE: state_d = SCH_IDLE;
      default:  state_d = SCH_IDLE;
    endcase
    if (i_cmd_abort) state_d = SCH_IDLE;
  end

  always_comb begin
    // Flags are consumed during LAUNCH; a same-cycle pulse re-arms without overrun.
    w_rdy_d   = w_set || (w_rdy_q && !consume);
    i_rdy_d   = i_set || (i_rdy_q && !consume);
    err_ovr_d = err_ovr_q || (w_set && w_rdy_q && !consume) || (i_set && i_rdy_q && !consume);
    err_tmo_d = err_tmo_q || (wd_hit && (state_d == SCH_ERROR));
    k_idx_d   = k_idx_q;
    n_idx_d   = n_idx_q;
    k_last_d  = k_last_q;
    n_last_d  = n_last_q;
    cc_d      = cc_q;

    if (pass_done && !last_k) begin
      k_idx_d = k_idx_q + CNT_W'(1);
    end else if (pass_done && !last_n) begin
      k_idx_d = '0;
      n_idx_d = n_idx_q + CNT_W'(1);
    end

    if (start_ok) begin
      k_last_d  = (i_cfg_k_tiles == '0) ? '0 : i_cfg_k_tiles - CNT_W'(1);
      n_last_d  = (i_cfg_n_tiles == '0) ? '0 : i_cfg_n_tiles - CNT_W'(1);
      cc_d      = i_cfg_compute_cycles;
      k_idx_d   = '0;
      n_idx_d   = '0;
      w_rdy_d   = 1'b0;
      i_rdy_d   = 1'b0;
      err_tmo_d = 1'b0;
      err_ovr_d = 1'b0;
    end

    if (state_d == SCH_IDLE) begin
      k_idx_d = '0;
      n_idx_d = '0;
    end

    if (i_cmd_abort) begin
      w_rdy_d   = 1'b0;
      i_rdy_d   = 1'b0;
      err_tmo_d = err_tmo_q;
      err_ovr_d = err_ovr_q;
      cc_d      = '0;
      k_last_d  = '0;
      n_last_d  = '0;
    end

    if ((state_d == SCH_IDLE) || (state_d == SCH_ERROR)) begin
      acc_d = 1'b0;
      oen_d = 1'b0;
    end else begin
      acc_d = (k_idx_d != '0);
      oen_d = (k_idx_d == k_last_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCH_IDLE;
      k_last_q  <= '0;
      n_last_q  <= '0;
      k_idx_q   <= '0;
      n_idx_q   <= '0;
      cc_q      <= '0;
      w_rdy_q   <= 1'b0;
      i_rdy_q   <= 1'b0;
      acc_q     <= 1'b0;
      oen_q     <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_last_q  <= k_last_d;
      n_last_q  <= n_last_d;
      k_idx_q   <= k_idx_d;
      n_idx_q   <= n_idx_d;
      cc_q      <= cc_d;
      w_rdy_q   <= w_rdy_d;
      i_rdy_q   <= i_rdy_d;
      acc_q     <= acc_d;
      oen_q     <= oen_d;
      err_tmo_q <= err_tmo_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  assign o_core_start         = consume && !i_cmd_abort && !rst;
  assign o_done               = (state_q == SCH_DONE) && !i_cmd_abort && !rst;
  assign o_busy               = sch_is_busy(state_q);
  assign o_cfg_compute_cycles = cc_q;
  assign o_cfg_acc_mode       = acc_q;
  assign o_cfg_output_en      = oen_q;
  assign o_err_timeout        = err_tmo_q;
  assign o_err_overrun        = err_ovr_q;
  assign o_k_idx              = k_idx_q;
  assign o_n_idx              = n_idx_q;

endmodule

// File: tb/tb_deit_tile_scheduler.sv
// Directed + randomized bench for deit_tile_scheduler; expected pass sequence
// comes from nested tile/pass loops, latencies from the timing rules.
module tb_deit_tile_scheduler;
  localparam int CW = 16;
  localparam int TW = 24;
  localparam int DG = 8;

  logic          clk;
  logic          rst;
  logic          i_cmd_start, i_cmd_abort;
  logic [CW-1:0] i_cfg_k_tiles, i_cfg_n_tiles;
  logic [31:0]   i_cfg_compute_cycles;
  logic [TW-1:0] i_cfg_timeout;
  logic          i_wbuf_ready, i_ibuf_ready, i_core_done, i_core_idle, i_obuf_empty;
  logic          o_core_start, o_cfg_acc_mode, o_cfg_output_en, o_busy, o_done;
  logic          o_err_timeout, o_err_overrun;
  logic [31:0]   o_cfg_compute_cycles;
  logic [CW-1:0] o_k_idx, o_n_idx;

  int errs = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  deit_tile_scheduler #(.CNT_W(CW), .TMO_W(TW), .DRAIN_GUARD(DG)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_start(i_cmd_start), .i_cmd_abort(i_cmd_abort),
    .i_cfg_k_tiles(i_cfg_k_tiles), .i_cfg_n_tiles(i_cfg_n_tiles),
    .i_cfg_compute_cycles(i_cfg_compute_cycles), .i_cfg_timeout(i_cfg_timeout),
    .i_wbuf_ready(i_wbuf_ready), .i_ibuf_ready(i_ibuf_ready),
    .i_core_done(i_core_done), .i_core_idle(i_core_idle), .i_obuf_empty(i_obuf_empty),
    .o_core_start(o_core_start), .o_cfg_compute_cycles(o_cfg_compute_cycles),
    .o_cfg_acc_mode(o_cfg_acc_mode), .o_cfg_output_en(o_cfg_output_en),
    .o_busy(o_busy), .o_done(o_done),
    .o_err_timeout(o_err_timeout), .o_err_overrun(o_err_overrun),
    .o_k_idx(o_k_idx), .o_n_idx(o_n_idx)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rdy(input logic w, input logic i);
    i_wbuf_ready = w;
    i_ibuf_ready = i;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({o_core_start, o_busy, o_done, o_cfg_acc_mode, o_cfg_output_en,
                            o_err_timeout, o_err_overrun}), 64'd0);
    chk({tag, "_idx"}, 64'({o_n_idx, o_k_idx}), 64'd0);
    chk({tag, "_cc"}, 64'(o_cfg_compute_cycles), 64'd0);
  endtask

  // mode: -1 random, 0 ready in WAIT, 1 prefetch in RUN, 2 pulse in LAUNCH cycle.
  // kill_pass >= 0: abort (or rst if kill_rst) during RUN of that pass.
  task automatic run_job(input int kc, input int nc, input int hold, input int mode,
                         input bit ovr, input int kill_pass, input bit kill_rst, input bit stall);
    int ke, ne, m, t, exp_t;
    bit pf;
    int exp_k[$];
    int exp_n[$];
    bit exp_acc[$];
    bit exp_oen[$];
    logic [31:0] cc;
    ke = (kc == 0) ? 1 : kc;
    ne = (nc == 0) ? 1 : nc;
    for (int nn = 0; nn < ne; nn++)
      for (int kk = 0; kk < ke; kk++) begin
        exp_k.push_back(kk);
        exp_n.push_back(nn);
        exp_acc.push_back(kk != 0);
        exp_oen.push_back(kk == ke - 1);
      end
    cc = $urandom;
    i_cfg_k_tiles = CW'(kc);
    i_cfg_n_tiles = CW'(nc);
    i_cfg_compute_cycles = cc;
    i_cmd_start = 1'b1;
    tick();
    i_cmd_start = 1'b0;
    chk("busy_after_start", 64'(o_busy), 64'd1);
    chk("errs_cleared", 64'({o_err_timeout, o_err_overrun}), 64'd0);
    chk("cfg_cc", 64'(o_cfg_compute_cycles), 64'(cc));
    pf = 1'b0;
    for (int p = 0; p < exp_k.size(); p++) begin
      if (pf) begin
        chk("gap_no_start", 64'(o_core_start), 64'd0);
        tick();
      end else if (stall && p == 0) begin
        i_core_idle = 1'b0;
        rdy(1, 1);
        tick();
        rdy(0, 0);
        chk("idle_gate", 64'(o_core_start), 64'd0);
        i_core_idle = 1'b1;
        tick();
      end else begin
        repeat ($urandom_range(0, 2)) tick();
        rdy(1, 1);
        tick();
        rdy(0, 0);
      end
      chk("launch", 64'(o_core_start), 64'd1);
      chk("acc_mode", 64'(o_cfg_acc_mode), 64'(exp_acc[p]));
      chk("output_en", 64'(o_cfg_output_en), 64'(exp_oen[p]));
      chk("idx_at_launch", 64'({o_n_idx, o_k_idx}), 64'({CW'(exp_n[p]), CW'(exp_k[p])}));
      m = (mode < 0) ? int'($urandom_range(0, 2)) : mode;
      if (p == exp_k.size() - 1 || (ovr && p == 0)) m = 0;
      if (m == 2) rdy(1, 1);
      tick();
      rdy(0, 0);
      if (p == kill_pass) begin
        if (kill_rst) rst = 1'b1;
        else          i_cmd_abort = 1'b1;
        tick();
        rst = 1'b0;
        i_cmd_abort = 1'b0;
        chk_all_zero(kill_rst ? "rst_mid" : "abort_mid");
        return;
      end
      if (ovr && p == 0) begin
        rdy(1, 1);
        tick();
        rdy(1, 0);
        tick();
        rdy(0, 0);
        chk("overrun_set", 64'(o_err_overrun), 64'd1);
      end else if (m == 1) begin
        rdy(1, 1);
        tick();
        rdy(0, 0);
      end
      repeat ($urandom_range(0, 3)) tick();
      chk("acc_stable", 64'(o_cfg_acc_mode), 64'(exp_acc[p]));
      chk("oen_stable", 64'(o_cfg_output_en), 64'(exp_oen[p]));
      i_core_done = 1'b1;
      tick();
      i_core_done = 1'b0;
      pf = (m != 0) || (ovr && p == 0);
      if (p < exp_k.size() - 1)
        chk("idx_update", 64'({o_n_idx, o_k_idx}), 64'({CW'(exp_n[p+1]), CW'(exp_k[p+1])}));
    end
    // First DRAIN cycle; obuf empty from tick 'hold' onwards.
    i_obuf_empty = (hold == 0);
    exp_t = ((hold > DG) ? hold : DG) + 1;
    t = 0;
    while (!o_done && t < hold + DG + 20) begin
      tick();
      t++;
      if (t == hold) i_obuf_empty = 1'b1;
    end
    i_obuf_empty = 1'b1;
    chk("done_latency", 64'(t), 64'(exp_t));
    tick();
    chk("done_one_cycle", 64'(o_done), 64'd0);
    chk("idle_busy", 64'(o_busy), 64'd0);
    chk("idle_idx", 64'({o_n_idx, o_k_idx}), 64'd0);
    chk("idle_ctl", 64'({o_cfg_acc_mode, o_cfg_output_en}), 64'd0);
    chk("overrun_final", 64'(o_err_overrun), 64'(ovr));
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    int t;
    rst = 1'b1;
    i_cmd_start = 0; i_cmd_abort = 0;
    i_cfg_k_tiles = '0; i_cfg_n_tiles = '0; i_cfg_compute_cycles = '0; i_cfg_timeout = '0;
    i_wbuf_ready = 0; i_ibuf_ready = 0; i_core_done = 0;
    i_core_idle = 1; i_obuf_empty = 1;
    repeat (3) tick();
    rst = 1'b0;
    chk_all_zero("reset");

    run_job(3, 2, 0, 1, 0, -1, 0, 0);
    run_job(3, 2, 0, 0, 0, -1, 0, 0);
    run_job(0, 0, 0, 0, 0, -1, 0, 0);
    run_job(2, 2, 0, 2, 1, -1, 0, 0);

    // Watchdog: core never finishes.
    i_cfg_timeout = TW'(100);
    i_cfg_k_tiles = CW'(1);
    i_cfg_n_tiles = CW'(1);
    i_cmd_start = 1'b1;
    tick();
    i_cmd_start = 1'b0;
    rdy(1, 1);
    tick();
    rdy(0, 0);
    chk("tmo_launch", 64'(o_core_start), 64'd1);
    tick();
    t = 0;
    while (o_busy && t < 300) begin
      tick();
      t++;
    end
    chk("tmo_latency", 64'(t), 64'd100);
    chk("tmo_err", 64'(o_err_timeout), 64'd1);
    chk("tmo_busy", 64'(o_busy), 64'd0);
    i_cfg_timeout = '0;
    run_job(2, 1, 0, -1, 0, -1, 0, 0);

    run_job(2, 1, 50, 0, 0, -1, 0, 0);
    run_job(3, 2, 0, -1, 0, 1, 0, 0);
    run_job(2, 2, 0, -1, 0, -1, 0, 1);
    run_job(2, 3, 0, -1, 0, 2, 1, 0);
    run_job(2, 2, 0, -1, 0, -1, 0, 0);

    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20)),
              -1, bit'($urandom_range(0, 1)), -1, 0, bit'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
